// File: rtl/siso_pkg.sv
// Shared constants and types for the SISO decoder LLR/extrinsic storage.
package siso_pkg;

  localparam int LLR_W     = 16;
  localparam int BLK_MAX   = 6144;
  localparam int TAIL_LEN  = 3;
  localparam int RAM_DEPTH = BLK_MAX + TAIL_LEN;

  typedef logic signed [LLR_W-1:0] llr_t;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_IDLE
  } ram_st_e;

endpackage

// File: rtl/siso_llr_dpram_if.sv
// Access bus of the LLR store: clear request, write port, read port and status.
interface siso_llr_dpram_if
  import siso_pkg::*;
#(
  parameter int DATA_W = LLR_W,
  parameter int ADDR_W = $clog2(RAM_DEPTH)
);

  logic              clr_req;
  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              oor_err;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  ready, rd_data, rd_valid, oor_err
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output ready, rd_data, rd_valid, oor_err
  );

endinterface

// File: rtl/siso_ram_clr_seq.sv
// Clear-sweep sequencer: walks every address once after reset or on request,
// then holds in IDLE with ready asserted.
module siso_ram_clr_seq
  import siso_pkg::*;
#(
  parameter int DEPTH  = RAM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_ready,
  output logic              o_sweep_we,
  output logic [ADDR_W-1:0] o_sweep_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_st_e           r_state;
  ram_st_e           w_state_next;
  logic [ADDR_W-1:0] r_sweep_addr;
  logic [ADDR_W-1:0] w_sweep_addr_next;
  logic              w_sweep_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_CLEAR;
      r_sweep_addr <= '0;
    end else begin
      r_state      <= w_state_next;
      r_sweep_addr <= w_sweep_addr_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_sweep_addr_next = r_sweep_addr;
    w_sweep_we        = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_sweep_we = 1'b1;
        if (r_sweep_addr == LAST_ADDR) begin
          w_state_next      = ST_IDLE;
          w_sweep_addr_next = '0;
        end else begin
          w_sweep_addr_next = r_sweep_addr + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_next      = ST_CLEAR;
          w_sweep_addr_next = '0;
        end
      end
      default: begin
        w_state_next      = ST_CLEAR;
        w_sweep_addr_next = '0;
      end
    endcase
  end

  assign o_ready      = (r_state == ST_IDLE);
  assign o_sweep_we   = w_sweep_we;
  assign o_sweep_addr = r_sweep_addr;

endmodule

// File: rtl/siso_llr_dpram.sv
// Simple-dual-port LLR/extrinsic store with hardware clear sweep and registered read.
// Optional macro SISO_RAM_OUTREG_EN adds an output pipeline register (read latency 2).
module siso_llr_dpram
  import siso_pkg::*;
#(
  parameter int                DATA_W   = LLR_W,
  parameter int                DEPTH    = RAM_DEPTH,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic             clk,
  input logic             rst_n,
  siso_llr_dpram_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic              w_ready;
  logic              w_sweep_we;
  logic [ADDR_W-1:0] w_sweep_addr;

  siso_ram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr_req    (bus.clr_req),
    .o_ready      (w_ready),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_addr (w_sweep_addr)
  );

  logic              w_wr_inrange;
  logic              w_rd_inrange;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [DATA_W-1:0] w_ram_wdata;

  assign w_wr_inrange = ({1'b0, bus.wr_addr} < DEPTH_X);
  assign w_rd_inrange = ({1'b0, bus.rd_addr} < DEPTH_X);
  assign w_wr_acc     = w_ready & bus.wr_en;
  assign w_rd_acc     = w_ready & bus.rd_en;

  // The sweep owns the write port while it runs; user accesses are only accepted in IDLE.
  assign w_ram_we    = w_sweep_we | (w_wr_acc & w_wr_inrange);
  assign w_ram_waddr = w_sweep_we ? w_sweep_addr : bus.wr_addr;
  assign w_ram_wdata = w_sweep_we ? INIT_VAL : bus.wr_data;
  assign w_ram_re    = w_rd_acc & w_rd_inrange;

  (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_dout;

  // Non-blocking write and read of the same cell give read-first behaviour.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_waddr] <= w_ram_wdata;
    end
    if (w_ram_re) begin
      r_ram_dout <= r_mem[bus.rd_addr];
    end
  end

  logic r_rd_valid;
  logic r_rd_oor;
  logic r_rd_seen;
  logic r_oor_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_rd_seen  <= 1'b0;
      r_oor_err  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_oor  <= ~w_rd_inrange;
        r_rd_seen <= 1'b1;
      end
      r_oor_err <= r_oor_err | (w_wr_acc & ~w_wr_inrange) | (w_rd_acc & ~w_rd_inrange);
    end
  end

  // The unreset RAM output is masked to zero until the first accepted read.
  logic [DATA_W-1:0] w_rd_word;
  assign w_rd_word = !r_rd_seen ? '0 : (r_rd_oor ? INIT_VAL : r_ram_dout);

`ifdef SISO_RAM_OUTREG_EN
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= r_rd_valid;
      if (r_rd_valid) begin
        r_out_data <= w_rd_word;
      end
    end
  end

  assign bus.rd_valid = r_out_valid;
  assign bus.rd_data  = r_out_data;
`else
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = w_rd_word;
`endif

  assign bus.ready   = w_ready;
  assign bus.oor_err = r_oor_err;

endmodule

// File: tb/tb_siso_llr_dpram.sv
// Directed self-checking bench for siso_llr_dpram (honours SISO_RAM_OUTREG_EN).
module tb_siso_llr_dpram;
  import siso_pkg::*;

  localparam int   DEPTH  = RAM_DEPTH;
  localparam int   ADDR_W = $clog2(DEPTH);
  localparam llr_t INIT   = '0;
`ifdef SISO_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  llr_t model [DEPTH];

  siso_llr_dpram_if #(.DATA_W(LLR_W), .ADDR_W(ADDR_W)) bus ();

  siso_llr_dpram #(
    .DATA_W   (LLR_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_VAL (INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic llr_t exp_word(input int a);
    return (a < DEPTH) ? model[a] : INIT;
  endfunction

  task automatic do_write(input int a, input llr_t d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    if (a < DEPTH) model[a] = d;
  endtask

  // Back-to-back reads of lo..hi; every pulse must land exactly LAT cycles after its request.
  task automatic read_range(input int lo, input int hi, input string name);
    llr_t q[$];
    llr_t e;
    int   n, popped, bad, bad_addr;
    llr_t bad_act, bad_exp;
    n = hi - lo + 1; popped = 0; bad = 0; bad_addr = -1; bad_act = '0; bad_exp = '0;
    for (int c = 0; c < n + LAT + 1; c++) begin
      if (c < n) begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(lo + c);
        q.push_back(exp_word(lo + c));
      end else begin
        bus.rd_en = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.rd_valid === 1'b1) begin
        if (q.size() == 0) begin
          bad++;
          if (bad == 1) begin bad_addr = -2; bad_act = bus.rd_data; bad_exp = '0; end
        end else begin
          e = q.pop_front();
          if (popped != c - (LAT - 1) || bus.rd_data !== e) begin
            bad++;
            if (bad == 1) begin bad_addr = lo + popped; bad_act = bus.rd_data; bad_exp = e; end
          end
          popped++;
        end
      end
    end
    checks++;
    if (bad != 0 || popped != n) begin
      failures++;
      $display("FAIL %s: %0d bad reads, %0d of %0d pulses, first at addr %0d got %h required %h",
               name, bad, popped, n, bad_addr, bad_act, bad_exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int c;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (bus.ready !== 1'b1 && c <= DEPTH + 4);
    checks++;
    if (c != DEPTH || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s: ready=%b after %0d cycles, required 1 after %0d", name, bus.ready, c, DEPTH);
    end
  endtask

  task automatic wait_valid(output llr_t d, output bit seen);
    seen = 1'b0; d = '0;
    for (int c = 0; c < 4; c++) begin
      if (bus.rd_valid === 1'b1) begin
        seen = 1'b1; d = bus.rd_data;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_outputs_reset(input string name);
    checks++;
    if (bus.ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.oor_err !== 1'b0) begin
      failures++;
      $display("FAIL %s: ready=%b rd_valid=%b rd_data=%h oor_err=%b, required 0/0/0000/0",
               name, bus.ready, bus.rd_valid, bus.rd_data, bus.oor_err);
    end
  endtask

  task automatic check_oor(input logic exp, input string name);
    checks++;
    if (bus.oor_err !== exp) begin
      failures++;
      $display("FAIL %s: oor_err=%b required %b", name, bus.oor_err, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_reset("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready("reset_ready_latency");
    read_range(0, DEPTH - 1, "init_all_words");
  endtask

  task automatic test_write_read();
    do_write(5, 16'h1234);
    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(5);
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      checks++;
      if (bus.rd_valid !== (c == LAT)) begin
        failures++;
        $display("FAIL rd_valid_cycle%0d: rd_valid=%b required %b", c, bus.rd_valid, (c == LAT));
      end
      if (c >= LAT) begin
        checks++;
        if (bus.rd_data !== 16'h1234) begin
          failures++;
          $display("FAIL rd_data_cycle%0d: rd_data=%h required 1234", c, bus.rd_data);
        end
      end
      if (c <= LAT) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_read_first();
    llr_t d;
    bit   seen;
    do_write(7, 16'h0001);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(7); bus.wr_data = 16'hBEEF;
    bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(7);
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    model[7] = 16'hBEEF;
    wait_valid(d, seen);
    checks++;
    if (!seen || d !== 16'h0001) begin
      failures++;
      $display("FAIL read_first_old: seen=%b rd_data=%h required 0001", seen, d);
    end
    read_range(7, 7, "read_first_new");
  endtask

  task automatic test_back_to_back();
    llr_t vec [8] = '{16'h1111, 16'h2222, 16'h8001, 16'h7FFF,
                      16'h0000, 16'hA5A5, 16'h5A5A, 16'hFFFE};
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(100 + i); bus.wr_data = vec[i];
      @(posedge clk); #1;
      model[100 + i] = vec[i];
    end
    bus.wr_en = 1'b0;
    read_range(98, 109, "back_to_back");
  endtask

  task automatic test_oor();
    check_oor(1'b0, "oor_before");
    read_range(DEPTH, DEPTH, "oor_read_depth");
    check_oor(1'b1, "oor_after_read");
    read_range((1 << ADDR_W) - 1, (1 << ADDR_W) - 1, "oor_read_max");
    do_write(DEPTH, 16'h9999);
    check_oor(1'b1, "oor_sticky");
    read_range(0, DEPTH - 1, "oor_write_dropped");
  endtask

  task automatic test_clear();
    int rdy_bad, vld_bad, rdy_first, vld_first;
    for (int a = 0; a < DEPTH; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = 16'hFFFF;
      @(posedge clk); #1;
      model[a] = 16'hFFFF;
    end
    bus.wr_en = 1'b0;
    read_range(0, 15, "fill_ffff");
    // clr_req with a concurrent read and write: the read must still return its data.
    bus.clr_req = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = ADDR_W'(3);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(4); bus.wr_data = 16'h4444;
    rdy_bad = 0; vld_bad = 0; rdy_first = -1; vld_first = -1;
    for (int j = 0; j <= DEPTH; j++) begin
      @(posedge clk); #1;
      if (bus.ready !== (j >= DEPTH)) begin
        rdy_bad++;
        if (rdy_first < 0) rdy_first = j;
      end
      if (bus.rd_valid !== (j == LAT - 1)) begin
        vld_bad++;
        if (vld_first < 0) vld_first = j;
      end
      if (j == LAT - 1) begin
        checks++;
        if (bus.rd_data !== 16'hFFFF) begin
          failures++;
          $display("FAIL clr_cycle_read: rd_data=%h required ffff", bus.rd_data);
        end
      end
      bus.clr_req = (j == 100);
      bus.rd_en   = (j < DEPTH - 1); bus.rd_addr = ADDR_W'(20);
      bus.wr_en   = (j < DEPTH - 1); bus.wr_addr = ADDR_W'(20); bus.wr_data = 16'h5555;
    end
    checks++;
    if (rdy_bad != 0) begin
      failures++;
      $display("FAIL clr_ready_profile: %0d wrong cycles, first at %0d, required 0", rdy_bad, rdy_first);
    end
    checks++;
    if (vld_bad != 0) begin
      failures++;
      $display("FAIL clr_valid_profile: %0d wrong cycles, first at %0d, required 0", vld_bad, vld_first);
    end
    for (int a = 0; a < DEPTH; a++) model[a] = INIT;
    read_range(0, DEPTH - 1, "clear_all_init");
  endtask

  task automatic test_reset_mid();
    do_write(10, 16'hABCD);
    read_range(10, 10, "pre_reset_read");
    bus.clr_req = 1'b1;
    @(posedge clk); #1;
    bus.clr_req = 1'b0;
    repeat (3000) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_reset("reset_mid_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("reset_mid_ready_latency");
    for (int a = 0; a < DEPTH; a++) model[a] = INIT;
    read_range(0, 20, "reset_mid_low");
    read_range(DEPTH - 5, DEPTH - 1, "reset_mid_high");
  endtask

  task automatic test_oor_write();
    check_oor(1'b0, "oor_cleared_by_reset");
    do_write(DEPTH + 1, 16'h7777);
    check_oor(1'b1, "oor_after_write");
  endtask

  initial begin
    bus.clr_req = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    for (int a = 0; a < DEPTH; a++) model[a] = INIT;
    test_reset();
    test_write_read();
    test_read_first();
    test_back_to_back();
    test_oor();
    test_clear();
    test_reset_mid();
    test_oor_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
